muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit between register-file read and register-file writeback.
- Consumes rs1/rs2 operands and destination register address; after a multi-cycle computation, produces write_data, ir3 and rf_wen for the register file's negedge write port.
- Execute stalls on busy.

---
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to compute MUL-class products in a single step.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            rf_wen,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
    state_t state;
    logic [2:0] op;
    logic neg, neg_rem;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] hi, lo, m;
    logic sign_a, sign_b, div_zero, ovf, div_ge;
    logic [XLEN-1:0] mag_a, mag_b, div_next, quo_s, rem_s, fin_val;
    logic [XLEN:0] mul_sum, div_rt;
    logic [2*XLEN-1:0] prod_s;
    // {hi,lo} is the product during MUL and {remainder,quotient} during DIV
    always_comb begin
        sign_a   = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'd1 || funct3[1:0] == 2'd2);
        sign_b   = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'd1);
        mag_a    = (sign_a && rs1[XLEN-1]) ? -rs1 : rs1;
        mag_b    = (sign_b && rs2[XLEN-1]) ? -rs2 : rs2;
        div_zero = funct3[2] && rs2 == '0;
        ovf      = funct3[2] && !funct3[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_rt   = {hi, lo[XLEN-1]};
        div_ge   = div_rt >= {1'b0, m};
        div_next = div_ge ? XLEN'(div_rt - {1'b0, m}) : div_rt[XLEN-1:0];
        prod_s   = neg ? -{hi, lo} : {hi, lo};
        quo_s    = neg ? -lo : lo;
        rem_s    = neg_rem ? -hi : hi;
        fin_val  = op[2] ? (op[1] ? rem_s : quo_s)
                         : (op[1:0] == 2'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rf_wen  <= 1'b0;
            rd_out  <= '0;
            result  <= '0;
            cnt     <= '0;
            op      <= '0;
            neg     <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            m       <= '0;
        end else begin
            done   <= 1'b0;
            rf_wen <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= start;
                        if (start) begin
                            op      <= funct3;
                            rd_out  <= rd;
                            cnt     <= '0;
                            neg     <= (sign_a && rs1[XLEN-1]) ^ (sign_b && rs2[XLEN-1]);
                            neg_rem <= sign_a && rs1[XLEN-1];
                            hi      <= '0;
                            if (div_zero || ovf) begin
                                // preload final quotient/remainder so FIN selects them unchanged
                                neg     <= 1'b0;
                                neg_rem <= 1'b0;
                                hi      <= div_zero ? rs1 : '0;
                                lo      <= div_zero ? '1 : rs1;
                                state   <= FIN;
                            end else if (funct3[2]) begin
                                m     <= mag_b;
                                lo    <= mag_a;
                                state <= DIV;
                            end else begin
`ifdef MULDIV_FAST_MUL_EN
                                {hi, lo} <= (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
                                state    <= FIN;
`else
                                m     <= mag_a;
                                lo    <= mag_b;
                                state <= MUL;
`endif
                            end
                        end
                    end
                    MUL, DIV: begin
                        {hi, lo} <= state == MUL ? {mul_sum, lo[XLEN-1:1]}
                                                 : {div_next, lo[XLEN-2:0], div_ge};
                        cnt      <= cnt + CNT_W'(1);
                        state    <= cnt == CNT_W'(XLEN-1) ? FIN : state;
                    end
                    default: begin
                        result <= fin_val;
                        done   <= 1'b1;
                        rf_wen <= rd_out != '0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clock = 1'b0;
    logic reset, start, flush;
    logic [2:0] funct3;
    logic [31:0] rs1, rs2;
    logic [4:0] rd;
    logic busy, done, rf_wen;
    logic [4:0] rd_out;
    logic [31:0] result;
    int tests = 0;
    int fails = 0;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush),
        .busy(busy), .done(done), .rf_wen(rf_wen), .rd_out(rd_out), .result(result)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        int ia, ib;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
            3'd6: return b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return f[2] ? 33 : MUL_LAT;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        @(negedge clock);
        funct3 = f; rs1 = a; rs2 = b; rd = r; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
    endtask

    task automatic wait_done(input int bound, output int lat);
        lat = -1;
        for (int n = 1; n <= bound; n++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if ({busy, done, rf_wen, rd_out, result} !== 40'h0) begin
            fails++; $display("FAIL reset_state got=%h want=0", {busy, done, rf_wen, rd_out, result});
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        tests++;
        if ({busy, done, rf_wen} !== 3'b000) begin
            fails++; $display("FAIL idle_after_reset got=%b want=000", {busy, done, rf_wen});
        end
    endtask

    task automatic test_directed;
        logic [2:0] f [12] = '{0, 1, 2, 3, 4, 6, 5, 7, 4, 6, 4, 6};
        logic [31:0] a [12] = '{7, 32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 5, 5, 32'h80000000, 32'h80000000};
        logic [31:0] b [12] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h80000000, 2, 2,
                                32'h10, 32'h10, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] want [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hC0000000, 32'h40000000, 32'hFFFFFFFD,
                                   32'hFFFFFFFF, 32'h0FFFFFFF, 32'hF, 32'hFFFFFFFF, 5, 32'h80000000, 0};
        int lat;
        for (int i = 0; i < 12; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 1));
            wait_done(40, lat);
            tests++;
            if (lat !== exp_lat(f[i], a[i], b[i])) begin
                fails++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", i, lat, exp_lat(f[i], a[i], b[i]));
            end
            tests++;
            if (result !== want[i]) begin
                fails++; $display("FAIL dir_result[%0d] got=%h want=%h", i, result, want[i]);
            end
            tests++;
            if ({rf_wen, rd_out, busy} !== {1'b1, 5'(i + 1), 1'b1}) begin
                fails++; $display("FAIL dir_wb[%0d] got=%b want=%b", i, {rf_wen, rd_out, busy}, {1'b1, 5'(i + 1), 1'b1});
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] pool [6] = '{0, 1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 2};
        logic [2:0] f;
        logic [31:0] a, b;
        logic [4:0] r;
        int lat;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 5)] : $urandom;
            b = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 5)] : $urandom;
            r = 5'($urandom);
            issue(f, a, b, r);
            wait_done(40, lat);
            tests++;
            if (lat !== exp_lat(f, a, b)) begin
                fails++; $display("FAIL rnd_latency f=%0d a=%h b=%h got=%0d want=%0d", f, a, b, lat, exp_lat(f, a, b));
            end
            tests++;
            if (result !== model(f, a, b)) begin
                fails++; $display("FAIL rnd_result f=%0d a=%h b=%h got=%h want=%h", f, a, b, result, model(f, a, b));
            end
            tests++;
            if ({rf_wen, rd_out, busy} !== {r != 0, r, 1'b1}) begin
                fails++; $display("FAIL rnd_wb got=%b want=%b", {rf_wen, rd_out, busy}, {r != 0, r, 1'b1});
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        issue(3'd5, 1000, 7, 5'd9);
        repeat (5) @(posedge clock);
        @(negedge clock);
        funct3 = 3'd0; rs1 = 32'd100; rs2 = 32'd3; rd = 5'd2; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(40, lat);
        tests++;
        if (lat + 6 !== 33) begin
            fails++; $display("FAIL busy_latency got=%0d want=33", lat + 6);
        end
        tests++;
        if ({result, rd_out} !== {32'd142, 5'd9}) begin
            fails++; $display("FAIL busy_result got=%h/%0d want=8e/9", result, rd_out);
        end
        @(posedge clock);
        #1;
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL busy_no_queue got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_flush;
        int lat;
        issue(3'd7, 1000, 7, 5'd3);
        wait_done(40, lat);
        tests++;
        if (result !== 32'd6) begin
            fails++; $display("FAIL flush_prev got=%h want=6", result);
        end
        issue(3'd4, 100, 5, 5'd4);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        tests++;
        if ({busy, done, rf_wen, result} !== {3'b000, 32'd6}) begin
            fails++; $display("FAIL flush_state got=%b/%h want=000/6", {busy, done, rf_wen}, result);
        end
        wait_done(40, lat);
        tests++;
        if (lat !== -1) begin
            fails++; $display("FAIL flush_no_done got=%0d want=-1", lat);
        end
        @(negedge clock);
        funct3 = 3'd0; rs1 = 2; rs2 = 3; rd = 5'd1; start = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0; flush = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL flush_start_idle got=%b want=0", busy);
        end
        wait_done(40, lat);
        tests++;
        if (lat !== -1 || result !== 32'd6) begin
            fails++; $display("FAIL flush_start_nodone got=%0d/%h want=-1/6", lat, result);
        end
    endtask

    task automatic test_reset_mid;
        issue(3'd4, 32'hFFFFFF00, 7, 5'd5);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, done, rf_wen, rd_out, result} !== 40'h0) begin
            fails++; $display("FAIL reset_mid got=%h want=0", {busy, done, rf_wen, rd_out, result});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_rd0;
        int lat;
        issue(3'd0, 3, 4, 5'd0);
        wait_done(40, lat);
        tests++;
        if (lat !== MUL_LAT) begin
            fails++; $display("FAIL rd0_latency got=%0d want=%0d", lat, MUL_LAT);
        end
        tests++;
        if ({result, rf_wen, rd_out} !== {32'd12, 1'b0, 5'd0}) begin
            fails++; $display("FAIL rd0_result got=%h/%b want=c/0", result, rf_wen);
        end
        @(posedge clock);
        #1;
        tests++;
        if ({busy, done, result} !== {2'b00, 32'd12}) begin
            fails++; $display("FAIL rd0_pulse got=%b/%h want=00/c", {busy, done}, result);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; rd = '0;
        test_reset;
        test_directed;
        test_random;
        test_busy_ignore;
        test_flush;
        test_reset_mid;
        test_rd0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
